// File: rtl/opb_reg_pkg.sv
// Shared definitions for the OPB register bank.
//   opb_state_t : slave handshake state (IDLE -> ACK -> RECOVER)
//   be_to_mask  : expands OPB byte enables into a 32-bit LSB-numbered lane mask
//   bus_to_le   : maps a big-endian-numbered [0:31] bus word onto [31:0]
//   le_to_bus   : the inverse mapping, used for read data
package opb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RECOVER = 2'd2
  } opb_state_t;

  localparam int OPB_WORD_BITS = 32;

  // BE[0] covers OPB bits 0..7, which is the most significant byte.
  function automatic logic [31:0] be_to_mask(input logic [0:3] be);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      mask[31-8*k -: 8] = {8{be[k]}};
    end
    return mask;
  endfunction

  // OPB bit 31 is the numeric LSB, so bus bit (31-i) lands on bit i.
  function automatic logic [31:0] bus_to_le(input logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [0:31] le_to_bus(input logic [31:0] v);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) begin
      r[31-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_reg_slice.sv
// One software register of the bank.
//   clk, srst : clock and synchronous active-high reset
//   wr_en     : single-cycle write request (already decoded for this register)
//   wr_data   : write data, LSB-aligned
//   wr_mask   : per-bit merge mask derived from the byte enables
//   value     : current register contents
//   valid     : one-cycle strobe, high in the cycle after a write edge
module opb_reg_slice
  import opb_reg_pkg::*;
#(
  parameter int          C_REG_WIDTH   = 32,
  parameter bit          C_PULSE       = 1'b0,
  parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   wr_en,
  input  logic [C_REG_WIDTH-1:0] wr_data,
  input  logic [C_REG_WIDTH-1:0] wr_mask,
  output logic [C_REG_WIDTH-1:0] value,
  output logic                   valid
);

  // One-shot registers always come out of reset cleared.
  localparam logic [C_REG_WIDTH-1:0] RESET_LOCAL =
    C_PULSE ? '0 : C_RESET_VALUE[C_REG_WIDTH-1:0];

  logic [C_REG_WIDTH-1:0] value_reg, value_next;
  logic                   valid_reg;

  always_comb begin
    value_next = value_reg;
    if (wr_en) begin
      value_next = (value_reg & ~wr_mask) | (wr_data & wr_mask);
    end else if (C_PULSE) begin
      // A written trigger is visible for exactly one cycle.
      value_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      value_reg <= RESET_LOCAL;
      valid_reg <= 1'b0;
    end else begin
      value_reg <= value_next;
      valid_reg <= wr_en;
    end
  end

  assign value = value_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of C_NUM_REGS software-written control registers behind one OPB slave window.
//   OPB_Clk / OPB_Rst      : clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW   : OPB request (big-endian bit numbering)
//   OPB_select             : transfer request; OPB_seqAddr is ignored
//   Sl_DBus                : read data, zero outside the read-ack cycle
//   Sl_xferAck / Sl_errAck : one-cycle ack; errAck flags an index past the bank
//   Sl_retry / Sl_toutSup  : tied low
//   user_data_out          : register i at [i*C_REG_WIDTH +: C_REG_WIDTH]
//   user_data_valid        : bit i pulses for one cycle when register i is written
module opb_register_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR    = 32'h00000000,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter int          C_REG_WIDTH   = 32,
  parameter logic [63:0] C_PULSE_MASK  = 64'h0,
  parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]           OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]         OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]           OPB_DBus,
  input  logic                              OPB_RNW,
  input  logic                              OPB_select,
  input  logic                              OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]           Sl_DBus,
  output logic                              Sl_xferAck,
  output logic                              Sl_errAck,
  output logic                              Sl_retry,
  output logic                              Sl_toutSup,
  output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]             user_data_valid
);

  localparam int IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  opb_state_t state_reg, state_next;

  logic             hit;
  logic [7:0]       idx;
  logic             idx_ok;
  logic             accept;
  logic [IDX_W-1:0] sel_reg;
  logic             rnw_reg;
  logic             err_reg;
  logic [31:0]      wr_word;
  logic [31:0]      wr_mask;
  logic [31:0]      rd_word;
  logic             unused_seq_addr;

  logic [C_REG_WIDTH-1:0] reg_value [C_NUM_REGS];

  assign unused_seq_addr = OPB_seqAddr;

  // Word offset inside the window (address bits 22..29 in OPB numbering).
  assign idx    = OPB_ABus[C_OPB_AWIDTH-10 : C_OPB_AWIDTH-3];
  assign idx_ok = (idx < 8'(C_NUM_REGS));
  assign hit    = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign accept = (state_reg == IDLE) && hit;

  assign wr_word = bus_to_le(OPB_DBus);
  assign wr_mask = be_to_mask(OPB_BE);

  // State register
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; RECOVER swallows a still-asserted select.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hit) state_next = ACK;
      ACK:     state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the fields needed during ACK are kept; the write itself is applied
  // from the live bus at the accepting edge.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      sel_reg <= '0;
      rnw_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (accept) begin
      sel_reg <= idx[IDX_W-1:0];
      rnw_reg <= OPB_RNW;
      err_reg <= !idx_ok;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
      logic wr_en;
      assign wr_en = accept && !OPB_RNW && (idx == 8'(gi));

      opb_reg_slice #(
        .C_REG_WIDTH   (C_REG_WIDTH),
        .C_PULSE       (C_PULSE_MASK[gi]),
        .C_RESET_VALUE (C_RESET_VALUE)
      ) u_slice (
        .clk     (OPB_Clk),
        .srst    (OPB_Rst),
        .wr_en   (wr_en),
        .wr_data (wr_word[C_REG_WIDTH-1:0]),
        .wr_mask (wr_mask[C_REG_WIDTH-1:0]),
        .value   (reg_value[gi]),
        .valid   (user_data_valid[gi])
      );

      assign user_data_out[gi*C_REG_WIDTH +: C_REG_WIDTH] = reg_value[gi];
    end
  endgenerate

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (sel_reg == IDX_W'(i)) begin
        rd_word[C_REG_WIDTH-1:0] = reg_value[i];
      end
    end
  end

  // Output logic; data bus stays zero outside a read ack so it can be OR-combined.
  always_comb begin
    Sl_xferAck = 1'b0;
    Sl_errAck  = 1'b0;
    Sl_DBus    = '0;
    if (state_reg == ACK) begin
      Sl_xferAck = 1'b1;
      Sl_errAck  = err_reg;
      if (rnw_reg && !err_reg) begin
        Sl_DBus = le_to_bus(rd_word);
      end
    end
  end

  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink. Two instances share
// the bus: "A" (32-bit regs, reg 0 one-shot) and "B" (12-bit regs).
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] A_BASE = 32'h8000_0000;
  localparam logic [31:0] A_HIGH = 32'h8000_00FF;
  localparam logic [31:0] B_BASE = 32'h9000_0000;
  localparam logic [31:0] B_HIGH = 32'h9000_000F;
  localparam logic [31:0] A_RST  = 32'h0000_5A5A;
  localparam logic [11:0] B_RST  = 12'h123;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw, sel, seq;

  logic [0:31]  a_dbus, b_dbus;
  logic         a_ack, a_err, a_retry, a_tout;
  logic         b_ack, b_err, b_retry, b_tout;
  logic [127:0] a_user;
  logic [3:0]   a_valid;
  logic [47:0]  b_user;
  logic [3:0]   b_valid;

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(A_BASE), .C_HIGHADDR(A_HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(4), .C_REG_WIDTH(32), .C_PULSE_MASK(64'h1), .C_RESET_VALUE(A_RST)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(a_dbus), .Sl_xferAck(a_ack), .Sl_errAck(a_err), .Sl_retry(a_retry),
    .Sl_toutSup(a_tout), .user_data_out(a_user), .user_data_valid(a_valid)
  );

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR(B_BASE), .C_HIGHADDR(B_HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(4), .C_REG_WIDTH(12), .C_PULSE_MASK(64'h0), .C_RESET_VALUE({20'h0, B_RST})
  ) dut_b (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(b_dbus), .Sl_xferAck(b_ack), .Sl_errAck(b_err), .Sl_retry(b_retry),
    .Sl_toutSup(b_tout), .user_data_out(b_user), .user_data_valid(b_valid)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected response per observed ack.
  always @(negedge clk) begin
    if (a_ack) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ack: got ack expected none (cycle %0d)", cyc);
      end else begin
        ea = q_a.pop_front();
        chk("a_ack_cycle", 128'(cyc), 128'(ea.cyc));
        chk("a_errack", {127'h0, a_err}, {127'h0, ea.err});
        chk("a_rdata", {96'h0, a_dbus}, {96'h0, ea.rdata});
      end
    end else begin
      chk("a_idle_dbus", {96'h0, a_dbus}, 128'h0);
      chk("a_idle_errack", {127'h0, a_err}, 128'h0);
    end
    if (b_ack) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ack: got ack expected none (cycle %0d)", cyc);
      end else begin
        eb = q_b.pop_front();
        chk("b_ack_cycle", 128'(cyc), 128'(eb.cyc));
        chk("b_errack", {127'h0, b_err}, {127'h0, eb.err});
        chk("b_rdata", {96'h0, b_dbus}, {96'h0, eb.rdata});
      end
    end else begin
      chk("b_idle_dbus", {96'h0, b_dbus}, 128'h0);
    end
  end

  // Issues one transfer from an idle slave and returns at the negedge of the ack cycle.
  task automatic xfer(input logic [31:0] addr, input logic [3:0] be_v, input logic [31:0] d,
                      input logic rd, input bit to_b, input bit exp_ack, input bit e_err,
                      input logic [31:0] e_rd);
    exp_t e;
    repeat (2) @(negedge clk);
    abus = addr; be = be_v; dbus = d; rnw = rd; sel = 1'b1;
    e.cyc = cyc + 1; e.err = e_err; e.rdata = e_rd;
    if (exp_ack) begin
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; sel = 1'b0; seq = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_a_user", a_user, {A_RST, A_RST, A_RST, 32'h0});
    chk("rst_b_user", {80'h0, b_user}, {80'h0, B_RST, B_RST, B_RST, B_RST});
    chk("rst_a_sl", {124'h0, a_ack, a_err, a_retry, a_tout}, 128'h0);
    chk("rst_b_sl", {124'h0, b_ack, b_err, b_retry, b_tout}, 128'h0);
    chk("rst_valid", {120'h0, a_valid, b_valid}, 128'h0);
    rst = 1'b0;

    // Full-word write to reg 2
    xfer(A_BASE + 8, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wr2_valid", {124'h0, a_valid}, 128'h4);
    chk("wr2_value", {96'h0, a_user[95:64]}, 128'hDEADBEEF);
    @(negedge clk);
    chk("wr2_valid_once", {124'h0, a_valid}, 128'h0);
    xfer(A_BASE + 8, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);

    // Byte-enable merge on reg 1
    xfer(A_BASE + 4, 4'b1111, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    xfer(A_BASE + 4, 4'b0101, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("be_merge", {96'h0, a_user[63:32]}, 128'h11BB33DD);
    xfer(A_BASE + 4, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11BB33DD);
    chk("read_no_valid", {124'h0, a_valid}, 128'h0);

    // One-shot reg 0
    xfer(A_BASE, 4'b1111, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("pulse_high", {96'h0, a_user[31:0]}, 128'h1);
    chk("pulse_valid", {124'h0, a_valid}, 128'h1);
    @(negedge clk);
    chk("pulse_cleared", {96'h0, a_user[31:0]}, 128'h0);
    xfer(A_BASE, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

    // Select held for 6 cycles: exactly two acks, 3 cycles apart
    repeat (2) @(negedge clk);
    abus = A_BASE + 8; be = 4'b1111; rnw = 1'b1; sel = 1'b1;
    e.err = 1'b0; e.rdata = 32'hDEADBEEF;
    e.cyc = cyc + 1; q_a.push_back(e);
    e.cyc = cyc + 4; q_a.push_back(e);
    repeat (6) @(negedge clk);
    sel = 1'b0;

    // Index past the bank: error ack, no register change
    xfer(A_BASE + 16, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("err_wr_valid", {124'h0, a_valid}, 128'h0);
    chk("err_wr_regs", a_user, {A_RST, 32'hDEADBEEF, 32'h11BB33DD, 32'h0});
    xfer(A_BASE + 20, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);

    // Reset sampled together with select: no ack, no write
    repeat (2) @(negedge clk);
    abus = A_BASE + 12; be = 4'b1111; dbus = 32'h12345678; rnw = 1'b0; sel = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rstx_ack", {126'h0, a_ack, a_err}, 128'h0);
    chk("rstx_regs", a_user, {A_RST, A_RST, A_RST, 32'h0});
    chk("rstx_valid", {124'h0, a_valid}, 128'h0);
    sel = 1'b0; rst = 1'b0;

    // Just past the window top: no response from anyone
    xfer(A_HIGH + 1, 4'b1111, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("oow_ack", {126'h0, a_ack, b_ack}, 128'h0);

    // 12-bit register instance
    xfer(B_BASE + 4, 4'b1111, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("b_wr_field", {80'h0, b_user}, {80'h0, B_RST, B_RST, 12'hFFF, B_RST});
    chk("b_wr_valid", {124'h0, b_valid}, 128'h2);
    xfer(B_BASE + 4, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000FFF);
    xfer(B_BASE + 4, 4'b0001, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("b_be_field", {116'h0, b_user[23:12]}, 128'hFAA);
    xfer(B_BASE + 4, 4'b1111, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000FAA);

    // Every expected ack must have been seen
    repeat (4) @(negedge clk);
    chk("a_pending", 128'(q_a.size()), 128'h0);
    chk("b_pending", 128'(q_b.size()), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
